// File: rtl/viterbi_chan_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_chan_pkg
// Shared types and constants for the channel error-injector stage that sits
// between the convolutional encoder and the Viterbi decoder.
//   sym_t          : one 2-bit encoded symbol {g1,g0}
//   chan_state_t   : statistics-window FSM states (IDLE, COUNT, DONE)
//   LFSR_SEED      : reset value of the optional pseudo-random injector
//   LFSR_TAPS      : x^16+x^14+x^13+x^11+1, bit i set for the x^(i+1) term
//   popcount2()    : number of set bits in a 2-bit value
// -----------------------------------------------------------------------------
package viterbi_chan_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } chan_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/chan_lfsr16.sv
// -----------------------------------------------------------------------------
// chan_lfsr16
// 16-bit Fibonacci LFSR used as the pseudo-random injection source when the
// build defines CHAN_LFSR_EN. Right-shifting form: the feedback bit enters at
// bit 15 and bit 0 leaves; tap bit i of LFSR_TAPS selects register bit 15-i.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (loads LFSR_SEED)
//   step_i   in   advance the register by one step this cycle
//   state_o  out  current register value (before this cycle's step)
// -----------------------------------------------------------------------------
module chan_lfsr16
  import viterbi_chan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step_i,
  output logic [15:0] state_o
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  always_comb begin
    w_fb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (LFSR_TAPS[i]) w_fb = w_fb ^ r_lfsr[15-i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (step_i) begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

  assign state_o = r_lfsr;

endmodule

// File: rtl/chan_error_injector.sv
// -----------------------------------------------------------------------------
// chan_error_injector
// Channel model for the tx/rx loopback: registers each encoded symbol (one
// cycle latency) and inverts the MASK bits on every PERIOD-th valid symbol.
// Counts valid symbols and injected bits over a WINDOW-symbol measurement
// window, after which the statistics freeze while injection carries on.
//
// Build option CHAN_LFSR_EN: injection slots come from a 16-bit LFSR
// (symbol corrupted when lfsr[2:0]==0, sampled before the step) instead of
// the phase counter; PERIOD is then unused.
//
// Handshake: a symbol is transferred on a rising edge where valid_i=1; there
// is no backpressure. valid_o is valid_i delayed one cycle and qualifies
// d_out/err_flag_o, which read 0 whenever valid_o=0.
//
// Ports:
//   clk, rst        clock / asynchronous active-low reset
//   valid_i, d_in   input symbol strobe and symbol {g1,g0}
//   inject_en_i     1 = corrupt injection slots, 0 = pass-through
//   valid_o, d_out  registered symbol to the decoder
//   err_flag_o      d_out carries injected errors
//   inj_bit_ct_o    injected bits inside the window (saturating)
//   word_ct_o       valid symbols inside the window (saturating)
//   window_done_o   window complete, statistics frozen
// -----------------------------------------------------------------------------
module chan_error_injector
  import viterbi_chan_pkg::*;
#(
  parameter int         PERIOD = 8,
  parameter logic [1:0] MASK   = 2'b11,
  parameter int         WINDOW = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [1:0]  d_in,
  input  logic        inject_en_i,
  output logic        valid_o,
  output logic [1:0]  d_out,
  output logic        err_flag_o,
  output logic [15:0] inj_bit_ct_o,
  output logic [15:0] word_ct_o,
  output logic        window_done_o
);

  localparam logic [15:0] WIN_LAST = 16'(WINDOW);
  localparam logic [16:0] INJ_STEP = 17'(popcount2(MASK));

  chan_state_t r_state;
  sym_t        r_dout;
  logic        r_valid;
  logic        r_err;
  logic [15:0] r_word_ct;
  logic [15:0] r_inj_ct;

  logic        w_slot;      // this valid symbol falls on an injection slot
  logic        w_corrupt;
  logic        w_count_en;
  logic [15:0] w_word_nxt;
  logic [16:0] w_inj_sum;
  logic [15:0] w_inj_nxt;

`ifdef CHAN_LFSR_EN
  logic [15:0] w_lfsr;

  chan_lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .step_i  (valid_i),
    .state_o (w_lfsr)
  );

  assign w_slot = (w_lfsr[2:0] == 3'b000);
`else
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD - 1);

  logic [PW-1:0] r_phase;

  // Phase keeps running while injection is disabled so slot alignment
  // survives inject_en_i toggles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
    end else if (valid_i) begin
      r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + 1'b1;
    end
  end

  assign w_slot = (r_phase == PHASE_LAST);
`endif

  assign w_corrupt  = valid_i & inject_en_i & w_slot;
  assign w_count_en = valid_i & (r_state != DONE);

  always_comb begin
    w_word_nxt = (r_word_ct == 16'hFFFF) ? r_word_ct : r_word_ct + 16'd1;
    w_inj_sum  = {1'b0, r_inj_ct} + INJ_STEP;
    w_inj_nxt  = w_inj_sum[16] ? 16'hFFFF : w_inj_sum[15:0];
  end

  // Output pipeline stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= valid_i;
      r_dout  <= valid_i ? (w_corrupt ? d_in ^ MASK : d_in) : 2'b00;
      r_err   <= w_corrupt;
    end
  end

  // Statistics window. The symbol that takes IDLE->COUNT is counted too, and
  // the symbol that fills the window is fully accounted before freezing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_word_ct <= '0;
      r_inj_ct  <= '0;
    end else if (w_count_en) begin
      r_word_ct <= w_word_nxt;
      if (w_corrupt) r_inj_ct <= w_inj_nxt;
      case (r_state)
        IDLE, COUNT: r_state <= (w_word_nxt == WIN_LAST) ? DONE : COUNT;
        default:     r_state <= r_state;
      endcase
    end
  end

  assign valid_o       = r_valid;
  assign d_out         = r_dout;
  assign err_flag_o    = r_err;
  assign word_ct_o     = r_word_ct;
  assign inj_bit_ct_o  = r_inj_ct;
  assign window_done_o = (r_state == DONE);

endmodule

// File: tb/tb_chan_error_injector.sv
// -----------------------------------------------------------------------------
// tb_chan_error_injector
// Two injector instances share one stimulus stream: dut_a with default
// parameters, dut_b with MASK=2'b01 and WINDOW=20. A symbol-level reference
// model (symbol index since reset, optional reference LFSR, window totals)
// predicts every output; per-cycle expected outputs go through a queue.
// -----------------------------------------------------------------------------
module tb_chan_error_injector;

  localparam int         PERIOD = 8;
  localparam logic [1:0] MASK_A = 2'b11;
  localparam logic [1:0] MASK_B = 2'b01;
  localparam int         WIN_A  = 256;
  localparam int         WIN_B  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  d_in = 2'b00;
  logic        inject_en_i = 1'b0;

  logic        a_valid, b_valid, a_err, b_err, a_done, b_done;
  logic [1:0]  a_dout, b_dout;
  logic [15:0] a_inj, b_inj, a_word, b_word;

  chan_error_injector #(.PERIOD(PERIOD), .MASK(MASK_A), .WINDOW(WIN_A)) dut_a (
    .clk(clk), .rst(rst), .valid_i(valid_i), .d_in(d_in), .inject_en_i(inject_en_i),
    .valid_o(a_valid), .d_out(a_dout), .err_flag_o(a_err),
    .inj_bit_ct_o(a_inj), .word_ct_o(a_word), .window_done_o(a_done)
  );

  chan_error_injector #(.PERIOD(PERIOD), .MASK(MASK_B), .WINDOW(WIN_B)) dut_b (
    .clk(clk), .rst(rst), .valid_i(valid_i), .d_in(d_in), .inject_en_i(inject_en_i),
    .valid_o(b_valid), .d_out(b_dout), .err_flag_o(b_err),
    .inj_bit_ct_o(b_inj), .word_ct_o(b_word), .window_done_o(b_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [3:0]  exp_q_a[$];   // {valid, d_out[1:0], err}
  logic [3:0]  exp_q_b[$];

  int          m_k;          // valid symbols since reset
  logic [15:0] m_lfsr;
  int          m_words[2];
  int          m_inj[2];
  bit          m_done[2];
  int          hits_first_256;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bits_set(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  function automatic bit model_slot();
`ifdef CHAN_LFSR_EN
    return (m_lfsr % 8) == 0;
`else
    return (m_k % PERIOD) == (PERIOD - 1);
`endif
  endfunction

  task automatic model_reset();
    m_k    = 0;
    m_lfsr = 16'hACE1;
    hits_first_256 = 0;
    for (int i = 0; i < 2; i++) begin
      m_words[i] = 0;
      m_inj[i]   = 0;
      m_done[i]  = 0;
    end
    exp_q_a.delete();
    exp_q_b.delete();
  endtask

  // Compare registered outputs against the queued prediction and the window totals.
  task automatic check_outputs();
    logic [3:0] ea, eb;
    if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
      check("queue_empty", 32'(exp_q_a.size() + exp_q_b.size()), 32'd2);
    end else begin
      ea = exp_q_a.pop_front();
      eb = exp_q_b.pop_front();
      check("a_valid", a_valid, ea[3]);
      check("a_dout",  a_dout,  ea[2:1]);
      check("a_err",   a_err,   ea[0]);
      check("b_valid", b_valid, eb[3]);
      check("b_dout",  b_dout,  eb[2:1]);
      check("b_err",   b_err,   eb[0]);
    end
    check("a_word", a_word, m_words[0]);
    check("a_inj",  a_inj,  m_inj[0]);
    check("a_done", a_done, m_done[0]);
    check("b_word", b_word, m_words[1]);
    check("b_inj",  b_inj,  m_inj[1]);
    check("b_done", b_done, m_done[1]);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [1:0] d, input bit en);
    bit         corrupt;
    logic [1:0] mask;
    logic [1:0] od;
    bit         fb;
    @(negedge clk);
    valid_i     = v;
    d_in        = d;
    inject_en_i = en;
    corrupt = v && en && model_slot();
    if (v && model_slot() && m_k < 256) hits_first_256++;
    for (int i = 0; i < 2; i++) begin
      mask = (i == 0) ? MASK_A : MASK_B;
      od   = v ? (corrupt ? (d ^ mask) : d) : 2'b00;
      if (i == 0) exp_q_a.push_back({v, od, corrupt});
      else        exp_q_b.push_back({v, od, corrupt});
      if (v && !m_done[i]) begin
        if (m_words[i] < 65535) m_words[i]++;
        if (corrupt) m_inj[i] += bits_set(mask);
        if (m_inj[i] > 65535) m_inj[i] = 65535;
        if (m_words[i] == ((i == 0) ? WIN_A : WIN_B)) m_done[i] = 1;
      end
    end
    if (v) begin
      m_k++;
      fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = {fb, m_lfsr[15:1]};
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {a_valid, a_dout, a_err, a_done, a_inj, a_word}, 32'd0);
    check({tag, "_b"}, {b_valid, b_dout, b_err, b_done, b_inj, b_word}, 32'd0);
  endtask

  // Reset asserted mid-cycle (asynchronous), outputs checked immediately.
  task automatic apply_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(negedge clk);
    valid_i     = 1'b0;
    d_in        = 2'b00;
    inject_en_i = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero({tag, "_hold"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b1;

    // 256 back-to-back symbols of 2'b01 with injection on
    for (int i = 0; i < 256; i++) drive(1'b1, 2'b01, 1'b1);
    check("win_a_words", a_word, 32'd256);
    check("win_a_done",  a_done, 32'd1);
    check("win_b_words", b_word, 32'd20);
`ifndef CHAN_LFSR_EN
    check("win_a_inj",   a_inj,  32'd64);
    check("win_b_inj",   b_inj,  32'd2);
`endif

    // one valid every three cycles
    apply_reset("rst_gap");
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b11, 1'b1);
      drive(1'b0, 2'($urandom_range(0, 3)), 1'b1);
      drive(1'b0, 2'($urandom_range(0, 3)), 1'b1);
    end

    // injection disabled for symbols 0-9, phase must be preserved
    apply_reset("rst_en");
    for (int i = 0; i < 16; i++) drive(1'b1, 2'($urandom_range(0, 3)), (i >= 10));
`ifndef CHAN_LFSR_EN
    check("en_toggle_inj", a_inj, 32'd2);
`endif

    // reset in the middle of a window
    apply_reset("rst_pre");
    for (int i = 0; i < 100; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b1);
    apply_reset("rst_mid");
    for (int i = 0; i < 10; i++) drive(1'b1, 2'b10, 1'b1);

    // long randomized run from a clean reset
    apply_reset("rst_rand");
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) != 0));
      if ($urandom_range(0, 5) == 0) drive(1'b0, 2'($urandom_range(0, 3)), 1'b1);
    end

    // full-injection run over the first window for the hit-count relation
    apply_reset("rst_hits");
    for (int i = 0; i < 256; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b1);
    check("hits_a_inj", a_inj, 32'(2 * hits_first_256));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
